adpcm_sr_dq_update: RTL and testbench

Writes the predictor history that the bit-serial predictor multiply-accumulate reads. One `start` operation takes the quantized difference DQ and signal estimate SE, reconstructs SR = SE + DQ in G.726 ADDB form, and converts DQ and SR to 11-bit floating format using FLOATA and FLOATB. It then shifts both into the delay lines DQ1..DQ6 and SR1..SR2. It sits between the inverse adaptive quantizer and the predictor. Its history outputs drive the predictor's DQn/SRn inputs directly.

---
 rtl/adpcm_sr_dq_update.sv | 189 ++++++++++++++++++
 tb/tb_adpcm_sr_dq_update.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_sr_dq_update.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_sr_dq_update
// Purpose  : Reconstructs SR = SE + DQ (ADDB form). Converts DQ and SR to the
//            11-bit float format used by the predictor (FLOATA/FLOATB) with a
//            fixed-length serial normaliser, then shifts both values into the
//            DQ1..DQ6 / SR1..SR2 history lines.
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_sr_dq_update (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] DQ,
  input  logic [14:0] SE,
  output logic        done,
  output logic [15:0] SR,
  output logic [10:0] DQ1,
  output logic [10:0] DQ2,
  output logic [10:0] DQ3,
  output logic [10:0] DQ4,
  output logic [10:0] DQ5,
  output logic [10:0] DQ6,
  output logic [10:0] SR1,
  output logic [10:0] SR2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    NORM   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // G.726 initial value of every history entry
  localparam logic [10:0] C_HIST_INIT = 11'd32;
  // Index of the last normalisation cycle (15 cycles: 0..14)
  localparam logic [3:0]  C_NORM_LAST = 4'd14;

  state_t      state_q, state_d;
  logic [15:0] dq_in_q, dq_in_d;
  logic [14:0] se_in_q, se_in_d;
  logic [15:0] sr_q, sr_d;
  logic [14:0] dq_mag_q, dq_mag_d, sr_mag_q, sr_mag_d;
  logic [3:0]  dq_exp_q, dq_exp_d, sr_exp_q, sr_exp_d;
  logic        dq_sign_q, dq_sign_d, sr_sign_q, sr_sign_d;
  logic        dq_zero_q, dq_zero_d, sr_zero_q, sr_zero_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] dq_hist_q [6];
  logic [10:0] dq_hist_d [6];
  logic [10:0] sr_hist_q [2];
  logic [10:0] sr_hist_d [2];

  logic [15:0] w_dq_neg, w_dqi, w_sei, w_sr_sum;
  logic [14:0] w_sr_mag;
  logic [10:0] w_dq_float, w_sr_float;

  // Reconstruction arithmetic on the captured operands and float packing
  always_comb begin
    w_dq_neg   = 16'd0 - {1'b0, dq_in_q[14:0]};
    w_dqi      = dq_in_q[15] ? w_dq_neg : dq_in_q;
    w_sei      = {se_in_q[14], se_in_q};
    w_sr_sum   = w_dqi + w_sei;
    // SR = 0x8000 folds to magnitude 0, matching the reference's 15-bit mask
    w_sr_mag   = w_sr_sum[15] ? (15'd0 - w_sr_sum[14:0]) : w_sr_sum[14:0];
    w_dq_float = {dq_sign_q, dq_exp_q, dq_zero_q ? 6'd32 : dq_mag_q[14:9]};
    w_sr_float = {sr_sign_q, sr_exp_q, sr_zero_q ? 6'd32 : sr_mag_q[14:9]};
  end

  // Next-state and datapath update for each phase of an operation
  always_comb begin
    state_d   = state_q;
    dq_in_d   = dq_in_q;
    se_in_d   = se_in_q;
    sr_d      = sr_q;
    dq_mag_d  = dq_mag_q;
    sr_mag_d  = sr_mag_q;
    dq_exp_d  = dq_exp_q;
    sr_exp_d  = sr_exp_q;
    dq_sign_d = dq_sign_q;
    sr_sign_d = sr_sign_q;
    dq_zero_d = dq_zero_q;
    sr_zero_d = sr_zero_q;
    cnt_d     = cnt_q;
    dq_hist_d = dq_hist_q;
    sr_hist_d = sr_hist_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dq_in_d = DQ;
          se_in_d = SE;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_d      = w_sr_sum;
        dq_mag_d  = dq_in_q[14:0];
        sr_mag_d  = w_sr_mag;
        dq_sign_d = dq_in_q[15];
        sr_sign_d = w_sr_sum[15];
        dq_zero_d = (dq_in_q[14:0] == 15'd0);
        sr_zero_d = (w_sr_mag == 15'd0);
        dq_exp_d  = 4'd15;
        sr_exp_d  = 4'd15;
        cnt_d     = 4'd0;
        state_d   = NORM;
      end
      NORM: begin
        // Fixed cycle count keeps the latency independent of the data
        if (!dq_mag_q[14] && (dq_exp_q != 4'd0)) begin
          dq_mag_d = {dq_mag_q[13:0], 1'b0};
          dq_exp_d = dq_exp_q - 4'd1;
        end
        if (!sr_mag_q[14] && (sr_exp_q != 4'd0)) begin
          sr_mag_d = {sr_mag_q[13:0], 1'b0};
          sr_exp_d = sr_exp_q - 4'd1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_NORM_LAST) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        for (int i = 5; i > 0; i--) begin
          dq_hist_d[i] = dq_hist_q[i-1];
        end
        dq_hist_d[0] = w_dq_float;
        sr_hist_d[1] = sr_hist_q[0];
        sr_hist_d[0] = w_sr_float;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dq_in_q   <= 16'd0;
      se_in_q   <= 15'd0;
      sr_q      <= 16'd0;
      dq_mag_q  <= 15'd0;
      sr_mag_q  <= 15'd0;
      dq_exp_q  <= 4'd0;
      sr_exp_q  <= 4'd0;
      dq_sign_q <= 1'b0;
      sr_sign_q <= 1'b0;
      dq_zero_q <= 1'b0;
      sr_zero_q <= 1'b0;
      cnt_q     <= 4'd0;
      for (int i = 0; i < 6; i++) begin
        dq_hist_q[i] <= C_HIST_INIT;
      end
      for (int i = 0; i < 2; i++) begin
        sr_hist_q[i] <= C_HIST_INIT;
      end
    end else begin
      state_q   <= state_d;
      dq_in_q   <= dq_in_d;
      se_in_q   <= se_in_d;
      sr_q      <= sr_d;
      dq_mag_q  <= dq_mag_d;
      sr_mag_q  <= sr_mag_d;
      dq_exp_q  <= dq_exp_d;
      sr_exp_q  <= sr_exp_d;
      dq_sign_q <= dq_sign_d;
      sr_sign_q <= sr_sign_d;
      dq_zero_q <= dq_zero_d;
      sr_zero_q <= sr_zero_d;
      cnt_q     <= cnt_d;
      dq_hist_q <= dq_hist_d;
      sr_hist_q <= sr_hist_d;
    end
  end

  assign done = (state_q == IDLE);
  assign SR   = sr_q;
  assign DQ1  = dq_hist_q[0];
  assign DQ2  = dq_hist_q[1];
  assign DQ3  = dq_hist_q[2];
  assign DQ4  = dq_hist_q[3];
  assign DQ5  = dq_hist_q[4];
  assign DQ6  = dq_hist_q[5];
  assign SR1  = sr_hist_q[0];
  assign SR2  = sr_hist_q[1];

endmodule
`default_nettype wire

// File: tb/tb_adpcm_sr_dq_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpcm_sr_dq_update
// Purpose  : Scoreboard bench for adpcm_sr_dq_update with a G.726 reference
//            model of SR reconstruction and float conversion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpcm_sr_dq_update;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] DQ;
  logic [14:0] SE;
  logic        done;
  logic [15:0] SR;
  logic [10:0] DQ1, DQ2, DQ3, DQ4, DQ5, DQ6, SR1, SR2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] sr;
    logic [10:0] dqh [6];
    logic [10:0] srh [2];
  } exp_t;

  exp_t        sb_q [$];
  logic [10:0] m_dq [6];
  logic [10:0] m_sr [2];

  adpcm_sr_dq_update dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .DQ    (DQ),
    .SE    (SE),
    .done  (done),
    .SR    (SR),
    .DQ1   (DQ1),
    .DQ2   (DQ2),
    .DQ3   (DQ3),
    .DQ4   (DQ4),
    .DQ5   (DQ5),
    .DQ6   (DQ6),
    .SR1   (SR1),
    .SR2   (SR2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Float of a sign/magnitude pair: value = mant * 2^exp / 64, mant in 32..63
  function automatic logic [10:0] to_float(input logic s, input int mag);
    int p;
    int m;
    if (mag == 0) return {s, 4'd0, 6'd32};
    p = 14;
    while (((mag >> p) & 1) == 0) p--;
    m = (mag << (14 - p)) >> 9;
    return {s, 4'(p + 1), 6'(m & 63)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_dq[i] = 11'd32;
    for (int i = 0; i < 2; i++) m_sr[i] = 11'd32;
  endfunction

  // Apply one accepted operation to the model and queue the expected outcome
  function automatic void model_op(input logic [15:0] dq, input logic [14:0] se);
    int   dqi, sei, sr, srmag;
    exp_t e;
    dqi   = dq[15] ? -int'(dq[14:0]) : int'(dq[14:0]);
    sei   = int'($signed(se));
    sr    = (dqi + sei) & 'hFFFF;
    srmag = (sr >= 'h8000) ? ((65536 - sr) & 'h7FFF) : sr;
    for (int i = 5; i > 0; i--) m_dq[i] = m_dq[i-1];
    m_dq[0] = to_float(dq[15], int'(dq[14:0]));
    m_sr[1] = m_sr[0];
    m_sr[0] = to_float(sr >= 'h8000, srmag);
    e.sr  = 16'(sr);
    e.dqh = m_dq;
    e.srh = m_sr;
    sb_q.push_back(e);
  endfunction

  // Monitor: on every done rising edge pop and compare one expected result
  logic prev_done = 1'b1;
  int   low_cnt   = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [10:0] act_dq [6];
    if (!reset) begin
      prev_done = 1'b1;
      low_cnt   = 0;
    end else begin
      if (!done) begin
        low_cnt++;
      end else if (!prev_done) begin
        chk("busy_cycles", low_cnt, 17);
        low_cnt = 0;
        if (sb_q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = sb_q.pop_front();
          act_dq = '{DQ1, DQ2, DQ3, DQ4, DQ5, DQ6};
          chk("SR", SR, e.sr);
          for (int i = 0; i < 6; i++) chk($sformatf("DQ%0d", i + 1), act_dq[i], e.dqh[i]);
          chk("SR1", SR1, e.srh[0]);
          chk("SR2", SR2, e.srh[1]);
        end
      end
      prev_done = done;
    end
  end

  // Issue one operation from a negedge with done high; returns at the negedge
  // where done is seen high again. Optional start pulses while busy.
  task automatic do_op(input logic [15:0] dq, input logic [14:0] se, input bit pulse);
    int k;
    DQ    = dq;
    SE    = se;
    start = 1'b1;
    model_op(dq, se);
    @(negedge clk);
    start = 1'b0;
    DQ    = 16'($urandom);
    SE    = 15'($urandom);
    k = 1;
    while (!done && k < 40) begin
      start = pulse && (k == 5 || k == 16);
      if (start) begin
        DQ = 16'($urandom);
        SE = 15'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_reset_values();
    chk("rst_done", done, 1);
    chk("rst_SR", SR, 0);
    chk("rst_DQ1", DQ1, 32);
    chk("rst_DQ2", DQ2, 32);
    chk("rst_DQ3", DQ3, 32);
    chk("rst_DQ4", DQ4, 32);
    chk("rst_DQ5", DQ5, 32);
    chk("rst_DQ6", DQ6, 32);
    chk("rst_SR1", SR1, 32);
    chk("rst_SR2", SR2, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    DQ    = 16'd0;
    SE    = 15'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();

    do_op(16'h0000, 15'h0000, 0);
    chk("zero_SR", SR, 16'h0000);
    chk("zero_DQ1", DQ1, 32);
    chk("zero_SR1", SR1, 32);

    do_op(16'h0005, 15'h0064, 0);
    chk("pos_SR", SR, 16'h0069);
    chk("pos_DQ1", DQ1, 232);
    chk("pos_SR1", SR1, 500);

    do_op(16'h8005, 15'h0000, 0);
    chk("neg_SR", SR, 16'hFFFB);
    chk("neg_DQ1", DQ1, 1256);
    chk("neg_SR1", SR1, 1256);

    do_op(16'h0005, 15'h7FFF, 0);
    chk("wrap_SR", SR, 16'h0004);
    chk("wrap_SR1", SR1, 224);

    do_op(16'h7FFF, 15'($urandom), 0);
    chk("max_DQ1", DQ1, 1023);

    do_op(16'h8000, 15'h0000, 0);
    chk("negzero_DQ1", DQ1, 1056);

    // Seven back-to-back updates with DQ magnitudes 1..7
    for (int i = 1; i <= 7; i++) do_op(16'(i), 15'($urandom), 0);
    chk("hist_DQ6", DQ6, to_float(1'b0, 2));
    chk("hist_DQ1", DQ1, to_float(1'b0, 7));

    // Start pulses while busy must be ignored
    do_op(16'($urandom), 15'($urandom), 1);
    repeat (2) @(negedge clk);
    chk("no_extra_op", sb_q.size(), 0);

    // Reset during normalisation aborts without touching history
    DQ    = 16'h1234;
    SE    = 15'h0456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();

    do_op(16'h0005, 15'h0064, 0);
    chk("post_rst_DQ1", DQ1, 232);
    chk("post_rst_DQ2", DQ2, 32);

    for (int i = 0; i < 30; i++) do_op(16'($urandom), 15'($urandom), ($urandom_range(0, 3) == 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
